// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// The key map is indexed by {row, col}.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } kp_state_e;

  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Resets to all-ones, which reads as "no key closed".
module keypad_row_sync import keypad_pkg::*; (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_ROWS-1:0] row_out
);

  logic [NUM_ROWS-1:0] meta_q, sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= row_in;
      sync_q <= meta_q;
    end
  end

  assign row_out = sync_q;

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 keypad scanner: drives one column low at a time, samples the rows,
// and debounces whole scan frames into a stable hex key code with strobes.
module keypad_scan_decoder import keypad_pkg::*; #(
  parameter int unsigned SCAN_TICKS = 100000,
  parameter int unsigned DB_SCANS   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_press,
  output logic                key_release,
  output logic                multi_key
);

  localparam int unsigned TICK_W = $clog2(SCAN_TICKS);
  localparam int unsigned CNT_W  = $clog2(DB_SCANS + 1);

  logic [NUM_ROWS-1:0] row_sync;

  keypad_row_sync u_row_sync (
    .clk     (clk),
    .reset   (reset),
    .row_in  (row),
    .row_out (row_sync)
  );

  logic [TICK_W-1:0] tick_q;
  logic [1:0]        col_idx_q;
  logic              sample, frame_end;

  assign sample    = (tick_q == TICK_W'(SCAN_TICKS - 1));
  assign frame_end = sample && (col_idx_q == 2'd3);
  assign col       = ~(NUM_COLS'(1) << col_idx_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q    <= '0;
      col_idx_q <= '0;
    end else if (sample) begin
      tick_q    <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      tick_q    <= tick_q + TICK_W'(1);
    end
  end

  // Closure count saturates at 2: only none / one / several matter.
  logic [1:0] acc_cnt_q, frame_cnt;
  logic [3:0] acc_code_q, frame_code;
  logic       frame_none, frame_single;

  always_comb begin
    frame_cnt  = acc_cnt_q;
    frame_code = acc_code_q;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!row_sync[r]) begin
        if (frame_cnt != 2'd2) frame_cnt = frame_cnt + 2'd1;
        frame_code = KEY_MAP[{2'(r), col_idx_q}];
      end
    end
  end

  assign frame_none   = (frame_cnt == 2'd0);
  assign frame_single = (frame_cnt == 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (frame_end) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (sample) begin
      acc_cnt_q  <= frame_cnt;
      acc_code_q <= frame_code;
    end
  end

  kp_state_e   state_q, state_d;
  logic [3:0]  cand_q, cand_d, key_code_q, key_code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        valid_q, valid_d, press_q, press_d, release_q, release_d, multi_q, multi_d;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    key_code_d = key_code_q;
    valid_d    = valid_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    multi_d    = multi_q;
    if (frame_end) begin
      multi_d = (frame_cnt == 2'd2);
      case (state_q)
        IDLE: begin
          if (frame_single) begin
            state_d = DB_PRESS;
            cand_d  = frame_code;
            cnt_d   = CNT_W'(1);
          end
        end
        DB_PRESS: begin
          if (frame_single && (frame_code == cand_q)) begin
            if (cnt_q == CNT_W'(DB_SCANS - 1)) begin
              state_d    = HELD;
              key_code_d = cand_q;
              valid_d    = 1'b1;
              press_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (frame_single) begin
            cand_d = frame_code;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (frame_none) begin
            state_d = DB_RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        DB_RELEASE: begin
          if (!frame_none) begin
            state_d = HELD;
          end else if (cnt_q == CNT_W'(DB_SCANS - 1)) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      key_code_q <= '0;
      valid_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      key_code_q <= key_code_d;
      valid_q    <= valid_d;
      press_q    <= press_d;
      release_q  <= release_d;
      multi_q    <= multi_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = valid_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder: directed frame table plus random frames
// checked against a frame-history model of the debounce rules.
module tb_keypad_scan_decoder;

  localparam int ST    = 8;
  localparam int DB    = 3;
  localparam int FRAME = 4 * ST;

  // Key printed at keypad position row*4+col.
  localparam logic [3:0] TB_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_press, key_release, multi_key;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_scan_decoder #(
    .SCAN_TICKS (ST),
    .DB_SCANS   (DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_press   (key_press),
    .key_release (key_release),
    .multi_key   (multi_key)
  );

  // Closed switch shorts its row to the column line while that column is low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Reference model: accept a press when the last DB frames all saw the same
  // single key; accept a release when the last DB frames were all empty.
  int         hist[$];
  logic       m_valid, m_press, m_release, m_multi;
  logic [3:0] m_code;

  function automatic int frame_result(input logic [15:0] k);
    int n = $countones(k);
    if (n == 0) return -1;
    if (n > 1) return -2;
    for (int p = 0; p < 16; p++) if (k[p]) return int'(TB_MAP[p]);
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_valid = 1'b0; m_press = 1'b0; m_release = 1'b0; m_multi = 1'b0; m_code = 4'h0;
  endtask

  task automatic model_frame(input int res);
    logic same;
    hist.push_back(res);
    if (hist.size() > DB) void'(hist.pop_front());
    m_press = 1'b0;
    m_release = 1'b0;
    m_multi = (res == -2);
    if (hist.size() == DB) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
      if (same && !m_valid && hist[0] >= 0) begin
        m_press = 1'b1; m_valid = 1'b1; m_code = 4'(hist[0]);
      end else if (same && m_valid && hist[0] == -1) begin
        m_release = 1'b1; m_valid = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic p, input logic r, input logic v,
                               input logic [3:0] code, input logic m);
    check({tag, "_press"},   32'(key_press),   32'(p));
    check({tag, "_release"}, 32'(key_release), 32'(r));
    check({tag, "_valid"},   32'(key_valid),   32'(v));
    check({tag, "_code"},    32'(key_code),    32'(code));
    check({tag, "_multi"},   32'(multi_key),   32'(m));
  endtask

  // Starts at cycle 0 of a frame (1 ns after the edge); ends at cycle 0 of the next.
  task automatic run_frame(input logic [15:0] k);
    int stray = 0;
    int colbad = 0;
    logic [3:0] exp_col;
    keys = k;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk); #1;
      exp_col = 4'b0001 << ((i / ST) % 4);
      exp_col = ~exp_col;
      if (col !== exp_col) colbad++;
      if (i < FRAME && (key_press || key_release)) stray++;
    end
    check("col_scan", 32'(colbad), 32'd0);
    check("no_mid_frame_strobe", 32'(stray), 32'd0);
    model_frame(frame_result(k));
  endtask

  typedef struct {
    logic [15:0] k;
    logic        p, r, v;
    logic [3:0]  code;
    logic        m;
  } vec_t;

  vec_t vecs [21];

  logic [15:0] prev;
  int          a, b;

  initial begin
    // key 5 = bit 5, key 9 = bit 10, keys 1+2 = bits 0,1, key D = bit 15
    vecs[0]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    vecs[1]  = '{16'h0020, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    vecs[2]  = '{16'h0020, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    vecs[3]  = '{16'h0020, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0};
    vecs[4]  = '{16'h0020, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0};
    vecs[5]  = '{16'h0020, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0};
    vecs[6]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0};
    vecs[7]  = '{16'h0020, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0};
    vecs[8]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0};
    vecs[9]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0};
    vecs[10] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0};
    vecs[11] = '{16'h0400, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0};
    vecs[12] = '{16'h0400, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0};
    vecs[13] = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0};
    vecs[14] = '{16'h0400, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0};
    vecs[15] = '{16'h0400, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0};
    vecs[16] = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0};
    vecs[17] = '{16'h0003, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1};
    vecs[18] = '{16'h0003, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1};
    vecs[19] = '{16'h0003, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1};
    vecs[20] = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_col", 32'(col), 32'hE);
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_frame(vecs[i].k);
      check_outputs($sformatf("vec%0d", i), vecs[i].p, vecs[i].r, vecs[i].v, vecs[i].code,
                    vecs[i].m);
    end

    // Press D, then reset in the middle of a frame while it is held.
    for (int f = 0; f < DB; f++) begin
      run_frame(16'h8000);
      check_outputs($sformatf("d_press%0d", f), m_press, m_release, m_valid, m_code, m_multi);
    end
    check("d_held_code", 32'(key_code), 32'hD);
    check("d_held_valid", 32'(key_valid), 32'd1);
    repeat (13) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_valid", 32'(key_valid), 32'd0);
    check("midreset_col", 32'(col), 32'hE);
    check("midreset_code", 32'(key_code), 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midreset_no_release", 32'(key_release), 32'd0);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int f = 0; f < DB; f++) begin
      run_frame(16'h8000);
      check_outputs($sformatf("d_repress%0d", f), m_press, m_release, m_valid, m_code, m_multi);
    end
    check("d_repress_strobe", 32'(key_press), 32'd1);
    check("d_repress_code", 32'(key_code), 32'hD);

    // Random frames; runs of repeated key sets give the debouncer something to accept.
    prev = 16'h8000;
    for (int f = 0; f < 60; f++) begin
      logic [15:0] k;
      case ($urandom_range(0, 9))
        0, 1, 2: k = 16'h0000;
        3, 4, 5: k = prev;
        6, 7, 8: k = 16'h0001 << $urandom_range(0, 15);
        default: begin
          a = int'($urandom_range(0, 15));
          b = (a + 1 + int'($urandom_range(0, 14))) % 16;
          k = (16'h0001 << a) | (16'h0001 << b);
        end
      endcase
      prev = k;
      run_frame(k);
      check_outputs($sformatf("rand%0d", f), m_press, m_release, m_valid, m_code, m_multi);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_decoder.md
Name: keypad_scan_decoder

Overview:
Input-side counterpart of the multiplexed 7-segment driver, for a 4x4 matrix keypad (Pmod KYPD style).
- Time-multiplexes the keypad columns, one low at a time, and samples the active-low rows.
- Debounces across whole scan frames.
- Delivers a stable 4-bit hex key code with press/release strobes.
- Its key_code feeds the hex digit inputs of the display mux, so the pressed key appears on the display.

Parameters:
SCAN_TICKS, 100000, clk cycles each column is driven (1 ms at 100 MHz); must be >= 4.
DB_SCANS, 4, consecutive identical scan frames required to accept a press or release; must be >= 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
row  in  4  keypad rows, active-low, externally pulled up; asynchronous to clk
col  out  4  keypad column drive, one-hot active-low
key_code  out  4  hex code of the accepted key; holds its last value after release
key_valid  out  1  high while an accepted key is held
key_press  out  1  one-cycle strobe on press acceptance
key_release  out  1  one-cycle strobe on release acceptance
multi_key  out  1  high if the last completed frame saw more than one key closed

Behaviour:
Reset and clocking
- Reset is asynchronous, active-high; clock is clk.
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_press=0, key_release=0, multi_key=0. All counters, the FSM and the synchronizer are cleared.
- Reset asserted mid-operation aborts everything; no release strobe is generated.

Column scan
- Column index c advances 0,1,2,3,0,... every SCAN_TICKS cycles.
- col drives bit c low (c=0: 1110, c=1: 1101, c=2: 1011, c=3: 0111).
- row passes through a 2-FF synchronizer. The synchronized rows are sampled on the last dwell cycle of each column, which allows settling time.
- A frame is 4 columns (4*SCAN_TICKS cycles). The frame ends on the sample cycle of column 3.
- The frame result is one of: NONE (no closure), SINGLE(code) (exactly one closure), or MULTI.
- multi_key updates at each frame end.

Key map (row r, col c -> code):
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: 0 F E D

FSM (evaluated only at frame end):
- IDLE
  - SINGLE(k): go to DB_PRESS, cand=k, cnt=1.
  - NONE or MULTI: stay in IDLE.
- DB_PRESS
  - SINGLE(cand): cnt+1. When cnt reaches DB_SCANS, go to HELD: key_code=cand, key_valid=1, key_press pulses for 1 cycle.
  - SINGLE(other k): restart with cand=k, cnt=1.
  - NONE or MULTI: go to IDLE.
- HELD
  - NONE: go to DB_RELEASE, cnt=1.
  - Any closure (including a different key or MULTI): stay in HELD; key_code is unchanged.
- DB_RELEASE
  - NONE: cnt+1. When cnt reaches DB_SCANS, go to IDLE: key_valid=0, key_release pulses for 1 cycle.
  - Any closure: return to HELD, no strobe.

Timing and widths
- Strobes and key_valid change on the cycle after the frame-end sample.
- A clean press present from a frame start is accepted DB_SCANS frames later.
- cnt width is $clog2(DB_SCANS+1).
- The tick counter width is $clog2(SCAN_TICKS); it wraps to 0 at SCAN_TICKS-1.

Decomposition:
Package keypad_pkg contains:
- the FSM state enum typedef {IDLE, DB_PRESS, HELD, DB_RELEASE}
- NUM_ROWS=4 and NUM_COLS=4
- the key map, as a constant 16-entry array indexed {row,col}

One sub-module, keypad_row_sync, is the 4-bit 2-FF synchronizer with asynchronous reset to 4'b1111.

Test Plan:
All scenarios use SCAN_TICKS=8 and DB_SCANS=3, giving a frame of 32 cycles.
1. Reset, no keys -> col=1110 during reset; 1101 at cycle 8, 1011 at 16, 0111 at 24, 1110 at 32; all outputs stay 0.
2. The keypad model closes key "5" (row[1]=0 while col[1]=0), held 5 frames -> exactly one key_press pulse after the 3rd frame end; key_code=4'h5, key_valid=1.
3. Bounce: "9" closed for 2 frames, open 1 frame, closed 2 frames -> no key_press; FSM returns to IDLE.
4. Release after scenario 2: keys open -> key_release pulses once after the 3rd empty frame; key_valid=0; key_code stays 4'h5. One empty frame followed by reclosure -> no strobe, key_valid stays 1.
5. From IDLE, keys "1" and "2" closed together -> multi_key=1 at the first frame end; no key_press while both are held.
6. Reset asserted while HELD on "D" -> key_valid=0 and col=1110 immediately; no key_release strobe. After reset deassertion with the key still held -> fresh key_press after 3 frames, key_code=4'hD.
